// File: rtl/ctrl_pipe_hazard.sv
// ctrl_pipe_hazard
//   ID-stage control decoder with registered ID/EX, EX/MEM and MEM/WB control
//   stages, load-use hazard detection (stall + bubble), branch flush and a
//   saturating stall-cycle counter for performance statistics.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   id_valid              IF/ID holds a real instruction
//   id_opcode, id_func    instruction opcode / function fields
//   id_rs, id_rt, id_rd   source 1, source 2 (store data), destination
//   flush                 kill the instruction in ID (taken branch)
//   stat_clr              clear stall_cnt
//   stall                 hold PC and IF/ID this cycle (combinational)
//   ex_*                  ID/EX control bits
//   mem_*                 EX/MEM control bits
//   wb_*                  MEM/WB control bits
//   stall_cnt             saturating count of stall cycles
module ctrl_pipe_hazard #(
  parameter int unsigned OPW      = 4,
  parameter int unsigned FNW      = 4,
  parameter int unsigned RAW      = 4,
  parameter int unsigned OP_LOAD  = 8,
  parameter int unsigned OP_STORE = 11,
  parameter int unsigned CNTW     = 16,
  parameter bit          R0_NOHAZ = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [OPW-1:0]  id_opcode,
  input  logic [FNW-1:0]  id_func,
  input  logic [RAW-1:0]  id_rs,
  input  logic [RAW-1:0]  id_rt,
  input  logic [RAW-1:0]  id_rd,
  input  logic            flush,
  input  logic            stat_clr,
  output logic            stall,
  output logic            ex_valid,
  output logic            ex_immd,
  output logic            ex_memwrite,
  output logic            ex_memread,
  output logic [1:0]      ex_regwrite,
  output logic [RAW-1:0]  ex_rd,
  output logic            mem_valid,
  output logic            mem_memwrite,
  output logic            mem_memread,
  output logic [1:0]      mem_regwrite,
  output logic [RAW-1:0]  mem_rd,
  output logic            wb_valid,
  output logic [1:0]      wb_regwrite,
  output logic [RAW-1:0]  wb_rd,
  output logic [CNTW-1:0] stall_cnt
);

  localparam logic [OPW-1:0]  OPC_LOAD  = OPW'(OP_LOAD);
  localparam logic [OPW-1:0]  OPC_STORE = OPW'(OP_STORE);
  localparam logic [OPW-1:0]  OPC_IMM_LO = OPW'(4);
  localparam logic [OPW-1:0]  OPC_IMM_HI = OPW'(6);
  localparam logic [FNW-1:0]  FN_IMM_LO = FNW'(8);
  localparam logic [FNW-1:0]  FN_IMM_HI = FNW'(11);
  localparam logic [FNW-1:0]  FN_RW2_A  = FNW'(4);
  localparam logic [FNW-1:0]  FN_RW2_B  = FNW'(5);
  localparam logic [CNTW-1:0] CNT_MAX   = '1;

  // ID-stage decode
  logic       op_zero;
  logic       dec_memwrite;
  logic       dec_memread;
  logic       dec_immd;
  logic [1:0] dec_regwrite;
  logic       rt_used;

  always_comb begin
    op_zero      = (id_opcode == '0);
    dec_memwrite = (id_opcode == OPC_STORE);
    dec_memread  = (id_opcode == OPC_LOAD);
    dec_immd     = ((id_opcode >= OPC_IMM_LO) && (id_opcode <= OPC_IMM_HI)) ||
                   (op_zero && (id_func >= FN_IMM_LO) && (id_func <= FN_IMM_HI));
    if (op_zero && ((id_func == FN_RW2_A) || (id_func == FN_RW2_B))) begin
      dec_regwrite = 2'd2;
    end else if (op_zero || dec_memread) begin
      dec_regwrite = 2'd1;
    end else begin
      dec_regwrite = 2'd0;
    end
    // Immediate forms replace rt with the immediate, except stores, which
    // still read rt as the data to be written.
    rt_used = ~dec_immd | dec_memwrite;
  end

  // Load-use hazard against the instruction sitting in EX. A bubble in EX
  // is excluded through ex_valid, so stale fields can never match.
  logic src_match;
  logic r0_exempt;
  logic hazard;
  logic id_load;

  always_comb begin
    src_match = (ex_rd == id_rs) || (rt_used && (ex_rd == id_rt));
    r0_exempt = R0_NOHAZ && (ex_rd == '0);
    hazard    = id_valid && ex_valid && ex_memread && src_match && !r0_exempt;
    // Flush outranks the hazard: the dependent instruction is being killed,
    // so there is nothing to hold.
    stall     = hazard && !flush;
    id_load   = id_valid && !flush && !hazard;
  end

  // ID/EX
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_immd     <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_regwrite <= 2'd0;
      ex_rd       <= '0;
    end else if (id_load) begin
      ex_valid    <= 1'b1;
      ex_immd     <= dec_immd;
      ex_memwrite <= dec_memwrite;
      ex_memread  <= dec_memread;
      ex_regwrite <= dec_regwrite;
      ex_rd       <= id_rd;
    end else begin
      ex_valid    <= 1'b0;
      ex_immd     <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_regwrite <= 2'd0;
      ex_rd       <= '0;
    end
  end

  // EX/MEM and MEM/WB always advance; bubbles are already all-zero in EX.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_valid    <= 1'b0;
      mem_memwrite <= 1'b0;
      mem_memread  <= 1'b0;
      mem_regwrite <= 2'd0;
      mem_rd       <= '0;
      wb_valid     <= 1'b0;
      wb_regwrite  <= 2'd0;
      wb_rd        <= '0;
    end else begin
      mem_valid    <= ex_valid;
      mem_memwrite <= ex_memwrite;
      mem_memread  <= ex_memread;
      mem_regwrite <= ex_regwrite;
      mem_rd       <= ex_rd;
      wb_valid     <= mem_valid;
      wb_regwrite  <= mem_regwrite;
      wb_rd        <= mem_rd;
    end
  end

  // Stall statistics: clear beats increment, count holds at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stat_clr) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// tb_ctrl_pipe_hazard
//   Two instances share one stimulus stream: dut_a with R0_NOHAZ=1 and
//   dut_b with R0_NOHAZ=0, both with a 4-bit stall counter. Each driven
//   instruction pushes its expected ID/EX entry onto a per-instance queue;
//   entries are compared as they appear in EX, MEM and WB and popped once
//   they leave WB.
module tb_ctrl_pipe_hazard;

  localparam int RAW  = 4;
  localparam int CNTW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            id_valid;
  logic [3:0]      id_opcode, id_func;
  logic [RAW-1:0]  id_rs, id_rt, id_rd;
  logic            flush, stat_clr;

  logic            stall_a, ex_valid_a, ex_immd_a, ex_memwrite_a, ex_memread_a;
  logic [1:0]      ex_regwrite_a, mem_regwrite_a, wb_regwrite_a;
  logic [RAW-1:0]  ex_rd_a, mem_rd_a, wb_rd_a;
  logic            mem_valid_a, mem_memwrite_a, mem_memread_a, wb_valid_a;
  logic [CNTW-1:0] stall_cnt_a;

  logic            stall_b, ex_valid_b, ex_immd_b, ex_memwrite_b, ex_memread_b;
  logic [1:0]      ex_regwrite_b, mem_regwrite_b, wb_regwrite_b;
  logic [RAW-1:0]  ex_rd_b, mem_rd_b, wb_rd_b;
  logic            mem_valid_b, mem_memwrite_b, mem_memread_b, wb_valid_b;
  logic [CNTW-1:0] stall_cnt_b;

  always #5 clk = ~clk;

  ctrl_pipe_hazard #(.CNTW(CNTW), .R0_NOHAZ(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_func(id_func), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .flush(flush), .stat_clr(stat_clr), .stall(stall_a),
    .ex_valid(ex_valid_a), .ex_immd(ex_immd_a), .ex_memwrite(ex_memwrite_a),
    .ex_memread(ex_memread_a), .ex_regwrite(ex_regwrite_a), .ex_rd(ex_rd_a),
    .mem_valid(mem_valid_a), .mem_memwrite(mem_memwrite_a),
    .mem_memread(mem_memread_a), .mem_regwrite(mem_regwrite_a), .mem_rd(mem_rd_a),
    .wb_valid(wb_valid_a), .wb_regwrite(wb_regwrite_a), .wb_rd(wb_rd_a),
    .stall_cnt(stall_cnt_a));

  ctrl_pipe_hazard #(.CNTW(CNTW), .R0_NOHAZ(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_func(id_func), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .flush(flush), .stat_clr(stat_clr), .stall(stall_b),
    .ex_valid(ex_valid_b), .ex_immd(ex_immd_b), .ex_memwrite(ex_memwrite_b),
    .ex_memread(ex_memread_b), .ex_regwrite(ex_regwrite_b), .ex_rd(ex_rd_b),
    .mem_valid(mem_valid_b), .mem_memwrite(mem_memwrite_b),
    .mem_memread(mem_memread_b), .mem_regwrite(mem_regwrite_b), .mem_rd(mem_rd_b),
    .wb_valid(wb_valid_b), .wb_regwrite(wb_regwrite_b), .wb_rd(wb_rd_b),
    .stall_cnt(stall_cnt_b));

  // entry layout: [9] valid [8] immd [7] memwrite [6] memread [5:4] regwrite [3:0] rd
  typedef logic [9:0] ent_t;
  localparam ent_t MEM_MASK = 10'b10_1111_1111;
  localparam ent_t WB_MASK  = 10'b10_0011_1111;

  ent_t q_a[$];
  ent_t q_b[$];
  int   cnt_a, cnt_b;
  int   n_chk  = 0;
  int   n_pass = 0;
  logic last_stall_a, last_stall_b, acc_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic ent_t decode_ent(input logic [3:0] op, input logic [3:0] fn,
                                      input logic [3:0] rd);
    logic       immd, mw, mr;
    logic [1:0] rw;
    mw = 1'b0; mr = 1'b0; immd = 1'b0; rw = 2'd0;
    case (op)
      4'd0: begin
        immd = (fn inside {[4'd8:4'd11]});
        rw   = (fn == 4'd4 || fn == 4'd5) ? 2'd2 : 2'd1;
      end
      4'd4, 4'd5, 4'd6: immd = 1'b1;
      4'd8:  begin mr = 1'b1; rw = 2'd1; end
      4'd11: mw = 1'b1;
      default: ;
    endcase
    return {1'b1, immd, mw, mr, rw, rd};
  endfunction

  function automatic logic exp_hazard(input ent_t ex, input logic r0, input ent_t d,
                                      input logic v, input logic [3:0] rs,
                                      input logic [3:0] rt);
    logic rt_used;
    rt_used = !d[8] || d[7];
    return v && ex[9] && ex[6] && ((ex[3:0] == rs) || (rt_used && ex[3:0] == rt)) &&
           !(r0 && ex[3:0] == 4'd0);
  endfunction

  function automatic int next_cnt(input int c, input logic st, input logic clr);
    if (clr) return 0;
    if (st && c != 15) return c + 1;
    return c;
  endfunction

  task automatic check_stages();
    check("ex_a",  {22'd0, ex_valid_a, ex_immd_a, ex_memwrite_a, ex_memread_a,
                    ex_regwrite_a, ex_rd_a}, {22'd0, q_a[2]});
    check("mem_a", {22'd0, mem_valid_a, 1'b0, mem_memwrite_a, mem_memread_a,
                    mem_regwrite_a, mem_rd_a}, {22'd0, q_a[1] & MEM_MASK});
    check("wb_a",  {22'd0, wb_valid_a, 3'b0, wb_regwrite_a, wb_rd_a},
                   {22'd0, q_a[0] & WB_MASK});
    check("cnt_a", {28'd0, stall_cnt_a}, cnt_a);
    check("ex_b",  {22'd0, ex_valid_b, ex_immd_b, ex_memwrite_b, ex_memread_b,
                    ex_regwrite_b, ex_rd_b}, {22'd0, q_b[2]});
    check("wb_b",  {22'd0, wb_valid_b, 3'b0, wb_regwrite_b, wb_rd_b},
                   {22'd0, q_b[0] & WB_MASK});
    check("cnt_b", {28'd0, stall_cnt_b}, cnt_b);
  endtask

  task automatic do_reset(input int ncyc);
    rst_n = 1'b0; id_valid = 1'b1; id_opcode = 4'd0; id_func = 4'd0;
    id_rs = 4'd0; id_rt = 4'd0; id_rd = 4'd0; flush = 1'b0; stat_clr = 1'b0;
    repeat (ncyc) @(posedge clk);
    #1;
    q_a.delete(); q_b.delete();
    repeat (3) begin q_a.push_back('0); q_b.push_back('0); end
    cnt_a = 0; cnt_b = 0;
    check_stages();
    check("rst_stall_a", stall_a, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic step(input logic v, input logic [3:0] op, input logic [3:0] fn,
                      input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd,
                      input logic fl, input logic clr);
    ent_t d;
    logic ha, hb, sa, sb;
    id_valid = v; id_opcode = op; id_func = fn; id_rs = rs; id_rt = rt; id_rd = rd;
    flush = fl; stat_clr = clr;
    #1;
    d  = decode_ent(op, fn, rd);
    ha = exp_hazard(q_a[2], 1'b1, d, v, rs, rt);
    hb = exp_hazard(q_b[2], 1'b0, d, v, rs, rt);
    sa = ha && !fl;
    sb = hb && !fl;
    last_stall_a = stall_a;
    last_stall_b = stall_b;
    check("stall_a", stall_a, sa);
    check("stall_b", stall_b, sb);
    acc_a = v && !fl && !ha;
    q_a.push_back(acc_a ? d : '0);
    q_b.push_back((v && !fl && !hb) ? d : '0);
    cnt_a = next_cnt(cnt_a, sa, clr);
    cnt_b = next_cnt(cnt_b, sb, clr);
    @(posedge clk);
    #1;
    void'(q_a.pop_front());
    void'(q_b.pop_front());
    check_stages();
  endtask

  task automatic nop();
    step(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset(2);

    // first instruction after reset release
    step(1'b1, 4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 1'b0, 1'b0);
    check("rel_ex_rw", ex_regwrite_a, 2'd1);
    check("rel_ex_rd", ex_rd_a, 4'd3);
    nop(); nop();
    check("rel_wb_rw", wb_regwrite_a, 2'd1);
    check("rel_wb_rd", wb_rd_a, 4'd3);

    // decode sweep; a stalled pair is re-presented until it is accepted
    for (int op = 0; op < 16; op++) begin
      for (int fn = 0; fn < 16; fn++) begin
        for (int tries = 0; tries < 3; tries++) begin
          step(1'b1, 4'(op), 4'(fn), 4'(op), 4'(fn), 4'(op + fn), 1'b0, 1'b0);
          if (acc_a) break;
        end
      end
    end

    step(1'b1, 4'd0, 4'd4, 4'd1, 4'd1, 4'd2, 1'b0, 1'b0);
    check("dir_rw2", ex_regwrite_a, 2'd2);
    step(1'b1, 4'd5, 4'd0, 4'd1, 4'd1, 4'd2, 1'b0, 1'b0);
    check("dir_immd", ex_immd_a, 1'b1);
    check("dir_immd_rw", ex_regwrite_a, 2'd0);
    step(1'b1, 4'd11, 4'd0, 4'd1, 4'd1, 4'd2, 1'b0, 1'b0);
    check("dir_store", ex_memwrite_a, 1'b1);

    // load-use: one stall, bubble, then the dependent op is accepted
    step(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    step(1'b1, 4'd8, 4'd0, 4'd1, 4'd1, 4'd5, 1'b0, 1'b0);
    step(1'b1, 4'd0, 4'd0, 4'd5, 4'd2, 4'd6, 1'b0, 1'b0);
    check("lu_stall", last_stall_a, 1'b1);
    check("lu_bubble", ex_valid_a, 1'b0);
    step(1'b1, 4'd0, 4'd0, 4'd5, 4'd2, 4'd6, 1'b0, 1'b0);
    check("lu_restall", last_stall_a, 1'b0);
    check("lu_accept", ex_valid_a, 1'b1);
    check("lu_cnt", stall_cnt_a, 4'd1);

    // rt only, on an immediate instruction: rt is not read
    step(1'b1, 4'd8, 4'd0, 4'd1, 4'd1, 4'd5, 1'b0, 1'b0);
    step(1'b1, 4'd5, 4'd0, 4'd1, 4'd5, 4'd6, 1'b0, 1'b0);
    check("rt_imm_stall", last_stall_a, 1'b0);

    // register 0 destination
    step(1'b1, 4'd8, 4'd0, 4'd1, 4'd1, 4'd0, 1'b0, 1'b0);
    step(1'b1, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 1'b0, 1'b0);
    check("r0_noh_a", last_stall_a, 1'b0);
    check("r0_haz_b", last_stall_b, 1'b1);
    step(1'b1, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 1'b0, 1'b0);

    // flush together with a hazard
    step(1'b1, 4'd8, 4'd0, 4'd1, 4'd1, 4'd5, 1'b0, 1'b0);
    step(1'b1, 4'd0, 4'd0, 4'd5, 4'd2, 4'd6, 1'b1, 1'b0);
    check("fl_stall", last_stall_a, 1'b0);
    check("fl_bubble", ex_valid_a, 1'b0);
    check("fl_load_mem", mem_memread_a, 1'b1);

    // saturation: alternating accept/stall gives 20 stall cycles
    step(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b1, 4'd8, 4'd0, 4'd7, 4'd7, 4'd7, 1'b0, 1'b0);
    check("sat_cnt", stall_cnt_a, 4'd15);
    nop();
    step(1'b1, 4'd8, 4'd0, 4'd1, 4'd1, 4'd7, 1'b0, 1'b0);
    step(1'b1, 4'd8, 4'd0, 4'd7, 4'd7, 4'd7, 1'b0, 1'b1);
    check("clr_stall", last_stall_a, 1'b1);
    check("clr_cnt", stall_cnt_a, 4'd0);

    // reset with the pipeline full
    step(1'b1, 4'd8, 4'd0, 4'd1, 4'd1, 4'd4, 1'b0, 1'b0);
    step(1'b1, 4'd0, 4'd4, 4'd2, 4'd2, 4'd6, 1'b0, 1'b0);
    do_reset(1);
    step(1'b1, 4'd0, 4'd0, 4'd1, 4'd2, 4'd9, 1'b0, 1'b0);
    check("post_rst_v", ex_valid_a, 1'b1);
    check("post_rst_rd", ex_rd_a, 4'd9);
    nop(); nop();
    check("post_rst_wb", wb_rd_a, 4'd9);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
